// File: rtl/counter_pkg.sv
// Shared constants and types for the two-digit BCD counter and its display path.
package counter_pkg;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT_0 = 7'h3F;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h06;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h5B;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h4F;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h66;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h6D;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h7D;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h07;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h7F;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h6F;
    localparam logic [6:0] SEG_BLANK   = 7'h00;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

endpackage

// File: rtl/bcd_counter_99_if.sv
// Control inputs and count/display outputs of the BCD counter, bundled for port wiring.
interface bcd_counter_99_if;

    logic       cnt_tick;
    logic       cnt_en;
    logic       cnt_up;
    logic       cnt_clr;
    logic [3:0] cnt_ones;
    logic [3:0] cnt_tens;
    logic       cnt_wrap;
    logic [6:0] seg_out;
    logic [1:0] seg_an;

    // Driver of the controls, consumer of count and display
    modport master (
        output cnt_tick, cnt_en, cnt_up, cnt_clr,
        input  cnt_ones, cnt_tens, cnt_wrap, seg_out, seg_an
    );

    // The counter itself
    modport slave (
        input  cnt_tick, cnt_en, cnt_up, cnt_clr,
        output cnt_ones, cnt_tens, cnt_wrap, seg_out, seg_an
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high seven-segment decoder; codes 10-15 decode to blank.
module seg7_decode
    import counter_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    // Table lookup, non-BCD codes blank the digit
    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_DIGIT_0;
            4'd1:    seg_o = SEG_DIGIT_1;
            4'd2:    seg_o = SEG_DIGIT_2;
            4'd3:    seg_o = SEG_DIGIT_3;
            4'd4:    seg_o = SEG_DIGIT_4;
            4'd5:    seg_o = SEG_DIGIT_5;
            4'd6:    seg_o = SEG_DIGIT_6;
            4'd7:    seg_o = SEG_DIGIT_7;
            4'd8:    seg_o = SEG_DIGIT_8;
            4'd9:    seg_o = SEG_DIGIT_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_counter_99.sv
// Two-digit up/down BCD counter stepped by rising edges of a slow tick, with a
// registered, time-multiplexed seven-segment display drive.
module bcd_counter_99
    import counter_pkg::*;
#(
    parameter int unsigned REFRESH_BITS   = 17,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input logic              fsys,
    input logic              cnt_rst_n,
    bcd_counter_99_if.slave  bus
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [1:0] AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    // tick_dly_q is the previous-cycle copy of cnt_tick used for edge detection
    logic                    tick_dly_q, tick_dly_d;
    logic                    step_q, step_d;
    bcd_t                    count_q, count_d;
    logic                    wrap_q, wrap_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [6:0]              seg_q, seg_d;
    logic [1:0]              an_q, an_d;

    logic       show_tens;
    logic [3:0] shown_digit;
    logic [6:0] seg_hi;

    // Edge detect: a qualified rising edge is registered and applied one cycle later;
    // clear in the detection cycle discards it so clear always wins.
    always_comb begin
        tick_dly_d = bus.cnt_tick;
        step_d     = bus.cnt_tick & ~tick_dly_q & bus.cnt_en & ~bus.cnt_clr;
    end

    // Next count value with decimal carry/borrow and 99<->00 wrap
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.cnt_clr) begin
            count_d = '0;
        end else if (step_q) begin
            if (bus.cnt_up) begin
                if (count_q.ones == DIGIT_MAX) begin
                    count_d.ones = 4'd0;
                    if (count_q.tens == DIGIT_MAX) begin
                        count_d.tens = 4'd0;
                        wrap_d       = 1'b1;
                    end else begin
                        count_d.tens = count_q.tens + 4'd1;
                    end
                end else begin
                    count_d.ones = count_q.ones + 4'd1;
                end
            end else begin
                if (count_q.ones == 4'd0) begin
                    count_d.ones = DIGIT_MAX;
                    if (count_q.tens == 4'd0) begin
                        count_d.tens = DIGIT_MAX;
                        wrap_d       = 1'b1;
                    end else begin
                        count_d.tens = count_q.tens - 4'd1;
                    end
                end else begin
                    count_d.ones = count_q.ones - 4'd1;
                end
            end
        end
    end

    // Display scan: refresh MSB picks the digit; segments and enables are registered together
    always_comb begin
        refresh_d   = refresh_q + REFRESH_ONE;
        show_tens   = refresh_q[REFRESH_BITS-1];
        shown_digit = show_tens ? count_q.tens : count_q.ones;
        seg_d       = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        an_d        = show_tens ? 2'b10 : 2'b01;
        if (SEG_ACTIVE_LOW) begin
            an_d = ~an_d;
        end
    end

    seg7_decode u_seg7_decode (
        .digit_i (shown_digit),
        .seg_o   (seg_hi)
    );

    // State registers; tick delay resets high so a tick already high at release is ignored
    always_ff @(posedge fsys or negedge cnt_rst_n) begin
        if (!cnt_rst_n) begin
            tick_dly_q <= 1'b1;
            step_q     <= 1'b0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            refresh_q  <= '0;
            seg_q      <= SEG_OFF;
            an_q       <= AN_OFF;
        end else begin
            tick_dly_q <= tick_dly_d;
            step_q     <= step_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            refresh_q  <= refresh_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign bus.cnt_ones = count_q.ones;
    assign bus.cnt_tens = count_q.tens;
    assign bus.cnt_wrap = wrap_q;
    assign bus.seg_out  = seg_q;
    assign bus.seg_an   = an_q;

endmodule

// File: tb/tb_bcd_counter_99.sv
// Self-checking bench for bcd_counter_99: directed sequences, a vector table and
// randomized stimulus against a value-level reference model.
module tb_bcd_counter_99;

    logic fsys  = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   wrap_cnt = 0;

    bcd_counter_99_if bus ();

    bcd_counter_99 #(
        .REFRESH_BITS   (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .fsys      (fsys),
        .cnt_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 fsys = ~fsys;

    // Reference model: count as an integer 0..99, scan as a cycle index mod 16
    logic [6:0] seg_tab [10];
    int         m_val, m_wrap, m_pend, m_prev, m_ref;
    logic [1:0] m_an;
    logic [6:0] m_seg;

    typedef struct {
        logic tick, en, up, clr;
        int   ones, tens, wrap;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_val  = 0;
        m_wrap = 0;
        m_pend = 0;
        m_prev = 1;
        m_ref  = 0;
        m_an   = 2'b11;
        m_seg  = 7'h7F;
    endtask

    task automatic model_edge(input logic tick, input logic en, input logic up, input logic clr);
        bit show_tens;
        int digit;
        show_tens = (m_ref >= 8);
        digit     = show_tens ? m_val / 10 : m_val % 10;
        m_an      = show_tens ? 2'b01 : 2'b10;
        m_seg     = ~seg_tab[digit];
        m_ref     = (m_ref + 1) % 16;
        if (clr) begin
            m_val  = 0;
            m_wrap = 0;
        end else if (m_pend != 0) begin
            if (up) begin
                m_wrap = (m_val == 99);
                m_val  = (m_val + 1) % 100;
            end else begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + 99) % 100;
            end
        end else begin
            m_wrap = 0;
        end
        m_pend = (tick && !m_prev && en && !clr);
        m_prev = tick;
    endtask

    task automatic check_model();
        chk("model_ones", bus.cnt_ones, m_val % 10);
        chk("model_tens", bus.cnt_tens, m_val / 10);
        chk("model_wrap", bus.cnt_wrap, m_wrap);
        chk("model_an",   bus.seg_an,   m_an);
        chk("model_seg",  bus.seg_out,  m_seg);
    endtask

    // One clock: drive at negedge, model the edge, sample at the next negedge
    task automatic cycle(input logic tick, input logic en, input logic up, input logic clr);
        bus.cnt_tick = tick;
        bus.cnt_en   = en;
        bus.cnt_up   = up;
        bus.cnt_clr  = clr;
        @(posedge fsys);
        model_edge(tick, en, up, clr);
        @(negedge fsys);
        check_model();
        wrap_cnt += int'(bus.cnt_wrap);
    endtask

    task automatic set_value(input int v);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < v; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0);
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
        end
    endtask

    function automatic int value_now();
        return int'(bus.cnt_tens) * 10 + int'(bus.cnt_ones);
    endfunction

    initial begin
        int an10, an01;
        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
        seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
        seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9, 9, 1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 9, 9, 0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 9, 9, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0};

        bus.cnt_tick = 1'b0;
        bus.cnt_en   = 1'b0;
        bus.cnt_up   = 1'b1;
        bus.cnt_clr  = 1'b0;
        model_reset();

        // Reset held while tick and clear toggle
        for (int i = 0; i < 6; i++) begin
            @(negedge fsys);
            bus.cnt_tick = ~bus.cnt_tick;
            bus.cnt_clr  = i[1];
            bus.cnt_en   = 1'b1;
            @(posedge fsys);
            @(negedge fsys);
            chk("reset_ones", bus.cnt_ones, 0);
            chk("reset_tens", bus.cnt_tens, 0);
            chk("reset_wrap", bus.cnt_wrap, 0);
            chk("reset_an",   bus.seg_an,   2'b11);
            chk("reset_seg",  bus.seg_out,  7'h7F);
        end

        // Release with tick already high: no count
        bus.cnt_tick = 1'b1;
        bus.cnt_clr  = 1'b0;
        rst_n        = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("release_high_tick", value_now(), 0);

        // Table-driven vectors from a cleared state
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].tick, tbl[i].en, tbl[i].up, tbl[i].clr);
            chk($sformatf("tbl%0d_ones", i), bus.cnt_ones, tbl[i].ones);
            chk($sformatf("tbl%0d_tens", i), bus.cnt_tens, tbl[i].tens);
            chk($sformatf("tbl%0d_wrap", i), bus.cnt_wrap, tbl[i].wrap);
        end

        // Up count through 100 edges
        wrap_cnt = 0;
        for (int e = 1; e <= 100; e++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0);
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
            if (e == 10)  chk("carry_09_to_10", value_now(), 10);
            if (e == 99)  chk("reach_99", value_now(), 99);
            if (e == 100) begin
                chk("wrap_to_00", value_now(), 0);
                chk("wrap_pulse", bus.cnt_wrap, 1);
            end
        end
        chk("single_wrap_in_100", wrap_cnt, 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("wrap_one_cycle", bus.cnt_wrap, 0);

        // Down count: 00 -> 99 wraps, 10 -> 09 does not
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("down_00_to_99", value_now(), 99);
        chk("down_wrap", bus.cnt_wrap, 1);
        set_value(10);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("down_10_to_09", value_now(), 9);
        chk("down_no_wrap", bus.cnt_wrap, 0);

        // Clear on the same cycle as a tick edge
        set_value(42);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_with_tick", value_now(), 0);
        chk("clr_wrap", bus.cnt_wrap, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("clr_no_late_step", value_now(), 0);

        // Disabled edges are discarded; re-enable mid-high does not count
        set_value(42);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0);
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("disabled_5_edges", value_now(), 42);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("reenable_mid_high", value_now(), 42);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("next_edge_counts", value_now(), 43);

        // Held tick: one step, one cycle after detection
        set_value(5);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("held_detect_cycle", value_now(), 5);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("held_latency", value_now(), 6);
        for (int i = 0; i < 998; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("held_single_step", value_now(), 6);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);

        // Display scan at 37
        set_value(37);
        an10 = 0;
        an01 = 0;
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
            if (bus.seg_an == 2'b10 && bus.seg_out == 7'h78) an10++;
            if (bus.seg_an == 2'b01 && bus.seg_out == 7'h30) an01++;
        end
        chk("disp_ones_7_cycles", an10, 16);
        chk("disp_tens_3_cycles", an01, 16);

        // Randomized stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            logic t;
            t = ($urandom_range(0, 2) == 0) ? ~bus.cnt_tick : bus.cnt_tick;
            cycle(t, ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset mid-operation, then resume
        set_value(58);
        @(posedge fsys);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ones", bus.cnt_ones, 0);
        chk("async_rst_tens", bus.cnt_tens, 0);
        chk("async_rst_an", bus.seg_an, 2'b11);
        chk("async_rst_seg", bus.seg_out, 7'h7F);
        model_reset();
        @(negedge fsys);
        bus.cnt_tick = 1'b0;
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("resume_after_reset", value_now(), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_counter_99.md
# bcd_counter_99

Two-digit BCD counter (00–99) with seven-segment display drive. It is the stage directly downstream of the clock divider: it takes the divider's slow tap output as its count tick, edge-detects it in the `fsys` domain, and steps an up/down counter with wrap. It then time-multiplexes the two digits onto a shared seven-segment bus with per-digit enables, and drives the board display.

## Interface
- `REFRESH_BITS`, default 17: width of the free-running display-scan counter. Its MSB selects the digit, giving a period of 2^REFRESH_BITS cycles.
- `SEG_ACTIVE_LOW`, default 1: 1 means `seg_out` and `seg_an` are active-low; 0 means active-high.
- `fsys`  in  1  system clock; all state is on its rising edge.
- `cnt_rst_n`  in  1  asynchronous, active-low reset.
- `cnt_tick`  in  1  slow square wave from the divider tap, synchronous to `fsys`; each rising edge is one count event.
- `cnt_en`  in  1  count enable; edges arriving while it is low are discarded, not queued.
- `cnt_up`  in  1  direction: 1 counts up, 0 counts down.
- `cnt_clr`  in  1  synchronous clear to 00.
- `cnt_ones`  out  4  BCD ones digit, 0–9.
- `cnt_tens`  out  4  BCD tens digit, 0–9.
- `cnt_wrap`  out  1  one-cycle pulse on a 99→00 (up) or 00→99 (down) transition.
- `seg_out`  out  7  segments {g,f,e,d,c,b,a}.
- `seg_an`  out  2  digit enables: bit 0 = ones digit, bit 1 = tens digit.

## Operation
- **Edge detect:** register `tick_d` samples `cnt_tick`.
  - step = `cnt_tick & ~tick_d & cnt_en`.
  - `tick_d` resets to 1, so a tick that is already high at reset release is not counted.
  - No synchronizer is used; the tick is already in the `fsys` domain.
- **Priority:** `cnt_clr` > step.
  - Clear forces 00 and `cnt_wrap`=0, regardless of tick, enable or direction.
- **Up step:**
  - ones 0–8: ones+1.
  - ones 9: ones→0 and tens+1.
  - 99: becomes 00 and asserts `cnt_wrap`.
- **Down step:**
  - ones 1–9: ones−1.
  - ones 0: ones→9 and tens−1.
  - 00: becomes 99 and asserts `cnt_wrap`.
- **Digit range:** digits never hold 10–15. Any such value is unreachable, and the decoder maps it to blank.
- **Direction change:** takes effect on the next step. It has no effect on the current value.
- **Display scan:**
  - The refresh counter runs freely, independent of `cnt_en`.
  - MSB=0: show ones, ones enable active.
  - MSB=1: show tens, tens enable active.
  - Exactly one digit is enabled at a time once out of reset.
  - The tens digit is shown even when it is 0 (no leading-zero blanking).
- **Reset mid-operation:** all registers take their reset values immediately, asynchronously. Counting resumes on the first qualifying edge after reset deasserts.

## Timing
- **Reset values:**
  - `cnt_ones`=0, `cnt_tens`=0, `cnt_wrap`=0.
  - Refresh counter = 0.
  - `seg_an` = both digits disabled (2'b11 when active-low).
  - `seg_out` = blank (7'h7F when active-low).
- **Count latency:** `cnt_tick` is first sampled high at edge N (with `tick_d` still low). The new digits are visible after edge N+1. `cnt_wrap` is high for exactly the cycle in which the wrapped value first appears.
- **Minimum tick rate:** at most one count per `cnt_tick` period. A tick held high for any number of cycles yields exactly one step.
- **Display latency:** `seg_out` and `seg_an` are registered and lag the scan select and digit values by one cycle. Both change on the same edge, so there is no cross-digit glitch.

## Structure
- **Package `counter_pkg`:**
  - `DIGIT_MAX` = 4'd9.
  - Active-high segment constants for digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - `SEG_BLANK` = 7'h00.
- **Sub-module `seg7_decode`:** combinational, 4-bit BCD to 7-bit active-high segments. The top level applies `SEG_ACTIVE_LOW` inversion before the output registers.

## Test plan
1. **Reset:** hold `cnt_rst_n` low while toggling `cnt_tick` and `cnt_clr` → ones=tens=0, `cnt_wrap`=0, `seg_an`=2'b11, `seg_out`=7'h7F for the whole reset; release with tick high → no count.
2. **Up count:** `cnt_en`=1, `cnt_up`=1, 100 tick edges from 00 → carry at 09→10; reaches 99 after 99 edges; the 100th edge gives 00 with `cnt_wrap` high for exactly one cycle and no other wrap pulses.
3. **Down count:** `cnt_up`=0 from 00, one edge → 99 with `cnt_wrap`=1; from 10, one edge → 09 with `cnt_wrap`=0.
4. **Clear and enable:**
   - At value 42, assert `cnt_clr` in the same cycle as a tick edge → 00, `cnt_wrap`=0.
   - `cnt_en`=0 across 5 edges → value unchanged.
   - Re-enable mid-high tick → no step until the next rising edge.
5. **Held tick:** `cnt_tick` held high for 1000 cycles at value 05 → exactly one step to 06, latency exactly 1 cycle after detection.
6. **Display:** `REFRESH_BITS`=4, `SEG_ACTIVE_LOW`=1, value 37 →
   - 8 cycles of `seg_an`=2'b10 with `seg_out`=7'h78 (digit 7),
   - then 8 cycles of `seg_an`=2'b01 with `seg_out`=7'h30 (digit 3),
   - repeating.
